stage_branch_register: RTL and testbench

- Holds the AGC stage register (ST1/ST2 bits) and the branch register (BR1/BR2).
- Sits directly upstream of the sequence-register/instruction-decode stage and supplies its ST0_n, ST1_n, STD2, ST3_n, BR2_n and BR1B2B inputs.
- Stage bits are requested during a memory cycle and take effect at end-of-MCT. Branch bits latch test results taken from the write bus and the G register.

---
 rtl/stage_branch_register.sv | 170 +++++++++++++++++
 tb/tb_stage_branch_register.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_branch_register.sv
// Stage register (ST1/ST2) and branch register (BR1/BR2).
// Stage requests accumulate in a pending pair and move into the current
// stage at end-of-MCT (T12 & PHS3). Branch bits latch tests of the write
// bus WL and the G register. Every output is a decode of registered state.
module stage_branch_register #(
    parameter int unsigned WORD_BITS    = 16,
    parameter bit          GOJAM_CLR_BR = 1'b0
) (
    input  logic                 SIM_CLK,
    input  logic                 SIM_RST,
    input  logic                 GOJAM,
    input  logic                 T12_n,
    input  logic                 PHS3_n,
    input  logic                 ST1,
    input  logic                 ST2,
    input  logic                 TRSM,
    input  logic                 RSTSTG,
    input  logic                 TSGN,
    input  logic                 TSGN2,
    input  logic                 TL15,
    input  logic                 TOV,
    input  logic                 TMZ,
    input  logic                 TPZG,
    input  logic [WORD_BITS-1:0] WL_n,
    input  logic [WORD_BITS-1:0] G_n,
    output logic                 ST0_n,
    output logic                 ST1_n,
    output logic                 ST3_n,
    output logic                 STD2,
    output logic                 BR1,
    output logic                 BR1_n,
    output logic                 BR2,
    output logic                 BR2_n,
    output logic                 BR1B2B,
    output logic                 BR1B2,
    output logic                 BR12B,
    output logic                 MST1,
    output logic                 MST2,
    output logic                 MBR1,
    output logic                 MBR2
);

    // AGC bit 16 (sign) and bit 15 in zero-based indexing.
    localparam int unsigned SIGN_IDX = WORD_BITS - 1;
    localparam int unsigned B15_IDX  = WORD_BITS - 2;

    // Minus-zero detect: every bit of the word set.
    function automatic logic all_ones(input logic [WORD_BITS-1:0] v);
        return &v;
    endfunction

    // Plus-zero detect: every bit of the word clear.
    function automatic logic all_zeros(input logic [WORD_BITS-1:0] v);
        return ~|v;
    endfunction

    logic                 cs1_r, cs2_r;
    logic                 ps1_r, ps2_r;
    logic                 br1_r, br2_r;
    logic [WORD_BITS-1:0] wl_s, g_s;
    logic                 xfer_s;
    logic                 ps1_upd_s, ps2_upd_s;
    logic                 br1_nxt_s, br2_nxt_s;

    // Bus polarity, transfer-cycle detect and pending-stage update (sets beat RSTSTG).
    always_comb begin
        wl_s      = ~WL_n;
        g_s       = ~G_n;
        xfer_s    = ~T12_n & ~PHS3_n;
        ps1_upd_s = (ps1_r & ~RSTSTG) | ST1;
        ps2_upd_s = (ps2_r & ~RSTSTG) | ST2 | TRSM;
    end

    // BR1 next value: TOV > TSGN > TL15, otherwise hold.
    always_comb begin
        br1_nxt_s = br1_r;
        if (TOV) begin
            br1_nxt_s = wl_s[SIGN_IDX];
        end else if (TSGN) begin
            br1_nxt_s = wl_s[SIGN_IDX];
        end else if (TL15) begin
            br1_nxt_s = wl_s[B15_IDX];
        end else begin
            br1_nxt_s = br1_r;
        end
    end

    // BR2 next value: TOV > TMZ > TPZG > TSGN2, otherwise hold.
    always_comb begin
        br2_nxt_s = br2_r;
        if (TOV) begin
            br2_nxt_s = wl_s[SIGN_IDX] ^ wl_s[B15_IDX];
        end else if (TMZ) begin
            br2_nxt_s = all_ones(wl_s);
        end else if (TPZG) begin
            br2_nxt_s = all_zeros(g_s);
        end else if (TSGN2) begin
            br2_nxt_s = wl_s[SIGN_IDX];
        end else begin
            br2_nxt_s = br2_r;
        end
    end

    // State registers: reset, restart, end-of-MCT stage transfer and branch latching.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            cs1_r <= 1'b0;
            cs2_r <= 1'b0;
            ps1_r <= 1'b0;
            ps2_r <= 1'b0;
            br1_r <= 1'b0;
            br2_r <= 1'b0;
        end else if (GOJAM) begin
            cs1_r <= 1'b0;
            cs2_r <= 1'b0;
            ps1_r <= 1'b0;
            ps2_r <= 1'b0;
            if (GOJAM_CLR_BR) begin
                br1_r <= 1'b0;
                br2_r <= 1'b0;
            end else begin
                br1_r <= br1_nxt_s;
                br2_r <= br2_nxt_s;
            end
        end else begin
            if (xfer_s) begin
                cs1_r <= ps1_upd_s;
                cs2_r <= ps2_upd_s;
                ps1_r <= 1'b0;
                ps2_r <= 1'b0;
            end else begin
                ps1_r <= ps1_upd_s;
                ps2_r <= ps2_upd_s;
            end
            br1_r <= br1_nxt_s;
            br2_r <= br2_nxt_s;
        end
    end

    // Stage decode of the current stage register.
    always_comb begin
        ST0_n = 1'b1;
        ST1_n = 1'b1;
        ST3_n = 1'b1;
        STD2  = 1'b0;
        case ({cs2_r, cs1_r})
            2'b00:   ST0_n = 1'b0;
            2'b01:   ST1_n = 1'b0;
            2'b10:   STD2  = 1'b1;
            2'b11:   ST3_n = 1'b0;
            default: ST0_n = 1'b1;
        endcase
    end

    // Branch decodes and monitor copies.
    always_comb begin
        BR1    = br1_r;
        BR1_n  = ~br1_r;
        BR2    = br2_r;
        BR2_n  = ~br2_r;
        BR1B2B = ~br1_r & ~br2_r;
        BR1B2  = ~br1_r &  br2_r;
        BR12B  =  br1_r & ~br2_r;
        MST1   = cs1_r;
        MST2   = cs2_r;
        MBR1   = br1_r;
        MBR2   = br2_r;
    end

endmodule

// File: tb/tb_stage_branch_register.sv
// Bench for stage_branch_register: a vector table applied in a loop with a
// scoreboard queue, then randomized branch tests against a small model.
// Two instances share stimulus: GOJAM_CLR_BR = 0 and GOJAM_CLR_BR = 1.
module tb_stage_branch_register;

    // ctrl bits
    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_RST  = 4'b1000;
    localparam logic [3:0] C_GJ   = 4'b0100;
    localparam logic [3:0] C_XF   = 4'b0010;
    localparam logic [3:0] C_T12  = 4'b0001;
    // strobe bits
    localparam logic [9:0] S_NONE   = 10'd0;
    localparam logic [9:0] S_ST1    = 10'b10_0000_0000;
    localparam logic [9:0] S_ST2    = 10'b01_0000_0000;
    localparam logic [9:0] S_TRSM   = 10'b00_1000_0000;
    localparam logic [9:0] S_RSTSTG = 10'b00_0100_0000;
    localparam logic [9:0] S_TSGN   = 10'b00_0010_0000;
    localparam logic [9:0] S_TSGN2  = 10'b00_0001_0000;
    localparam logic [9:0] S_TL15   = 10'b00_0000_1000;
    localparam logic [9:0] S_TOV    = 10'b00_0000_0100;
    localparam logic [9:0] S_TMZ    = 10'b00_0000_0010;
    localparam logic [9:0] S_TPZG   = 10'b00_0000_0001;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [9:0]  strb;
        logic [15:0] wl_n;
        logic [15:0] g_n;
        logic [1:0]  exp_cs;   // {cs2,cs1}
        logic [1:0]  exp_br0;  // {br2,br1}, GOJAM_CLR_BR=0
        logic [1:0]  exp_br1;  // {br2,br1}, GOJAM_CLR_BR=1
    } vec_t;

    typedef struct {
        string       name;
        logic [14:0] outs0;
        logic [14:0] outs1;
    } exp_t;

    logic clk;
    logic sim_rst, gojam, t12_n, phs3_n;
    logic st1, st2, trsm, rststg, tsgn, tsgn2, tl15, tov, tmz, tpzg;
    logic [15:0] wl_n, g_n;
    wire  [14:0] out0, out1;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total;
    int   bad;

    stage_branch_register #(.WORD_BITS(16), .GOJAM_CLR_BR(1'b0)) dut0 (
        .SIM_CLK(clk), .SIM_RST(sim_rst), .GOJAM(gojam), .T12_n(t12_n), .PHS3_n(phs3_n),
        .ST1(st1), .ST2(st2), .TRSM(trsm), .RSTSTG(rststg),
        .TSGN(tsgn), .TSGN2(tsgn2), .TL15(tl15), .TOV(tov), .TMZ(tmz), .TPZG(tpzg),
        .WL_n(wl_n), .G_n(g_n),
        .ST0_n(out0[14]), .ST1_n(out0[13]), .ST3_n(out0[12]), .STD2(out0[11]),
        .BR1(out0[10]), .BR1_n(out0[9]), .BR2(out0[8]), .BR2_n(out0[7]),
        .BR1B2B(out0[6]), .BR1B2(out0[5]), .BR12B(out0[4]),
        .MST1(out0[3]), .MST2(out0[2]), .MBR1(out0[1]), .MBR2(out0[0])
    );

    stage_branch_register #(.WORD_BITS(16), .GOJAM_CLR_BR(1'b1)) dut1 (
        .SIM_CLK(clk), .SIM_RST(sim_rst), .GOJAM(gojam), .T12_n(t12_n), .PHS3_n(phs3_n),
        .ST1(st1), .ST2(st2), .TRSM(trsm), .RSTSTG(rststg),
        .TSGN(tsgn), .TSGN2(tsgn2), .TL15(tl15), .TOV(tov), .TMZ(tmz), .TPZG(tpzg),
        .WL_n(wl_n), .G_n(g_n),
        .ST0_n(out1[14]), .ST1_n(out1[13]), .ST3_n(out1[12]), .STD2(out1[11]),
        .BR1(out1[10]), .BR1_n(out1[9]), .BR2(out1[8]), .BR2_n(out1[7]),
        .BR1B2B(out1[6]), .BR1B2(out1[5]), .BR12B(out1[4]),
        .MST1(out1[3]), .MST2(out1[2]), .MBR1(out1[1]), .MBR2(out1[0])
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word for a given stage {cs2,cs1} and branch {br2,br1}.
    function automatic logic [14:0] decode(input logic [1:0] cs, input logic [1:0] br);
        logic b1, b2;
        b1 = br[0];
        b2 = br[1];
        return {cs != 2'd0, cs != 2'd1, cs != 2'd3, cs == 2'd2,
                b1, !b1, b2, !b2, !b1 && !b2, !b1 && b2, b1 && !b2,
                cs[0], cs[1], b1, b2};
    endfunction

    task automatic add(input string nm, input logic [3:0] c, input logic [9:0] s,
                       input logic [15:0] wln, input logic [15:0] gn,
                       input logic [1:0] ecs, input logic [1:0] eb0, input logic [1:0] eb1);
        vec_t v;
        v.name = nm; v.ctrl = c; v.strb = s; v.wl_n = wln; v.g_n = gn;
        v.exp_cs = ecs; v.exp_br0 = eb0; v.exp_br1 = eb1;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] c, input logic [9:0] s,
                         input logic [15:0] wln, input logic [15:0] gn);
        sim_rst = c[3];
        gojam   = c[2];
        t12_n   = ~(c[1] | c[0]);
        phs3_n  = ~c[1];
        {st1, st2, trsm, rststg, tsgn, tsgn2, tl15, tov, tmz, tpzg} = s;
        wl_n = wln;
        g_n  = gn;
    endtask

    // Pop one scoreboard entry and compare both instances.
    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty got=%0d required>0", exp_q.size());
        end else begin
            e = exp_q.pop_front();
            total++;
            if (out0 !== e.outs0) begin
                bad++;
                $display("FAIL %s clr0 got=%b required=%b", e.name, out0, e.outs0);
            end
            total++;
            if (out1 !== e.outs1) begin
                bad++;
                $display("FAIL %s clr1 got=%b required=%b", e.name, out1, e.outs1);
            end
        end
    endtask

    // Apply one cycle of stimulus, queue its expectation, check after the edge.
    task automatic step(input string nm, input logic [3:0] c, input logic [9:0] s,
                        input logic [15:0] wln, input logic [15:0] gn,
                        input logic [1:0] ecs, input logic [1:0] eb0, input logic [1:0] eb1);
        exp_t e;
        @(negedge clk);
        drive(c, s, wln, gn);
        e.name  = nm;
        e.outs0 = decode(ecs, eb0);
        e.outs1 = decode(ecs, eb1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        logic [9:0]  rs;
        logic [15:0] rwl_n, rg_n, wl, g;
        logic        m1, m2;
        total = 0;
        bad   = 0;
        drive(C_RST, S_NONE, 16'hFFFF, 16'h0000);

        // name, ctrl, strobes, WL_n, G_n, cs, br(clr0), br(clr1)
        add("rst1",        C_RST,  S_NONE,          16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("rst2",        C_RST,  S_NONE,          16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("idle",        C_NONE, S_NONE,          16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("req_st3",     C_NONE, S_ST1 | S_ST2,   16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("xfer_st3",    C_XF,   S_NONE,          16'hFFFF, 16'h0000, 2'd3, 2'b00, 2'b00);
        add("tsgn_set",    C_NONE, S_TSGN,          16'h7FFF, 16'h0000, 2'd3, 2'b01, 2'b01);
        add("tsgn2_set",   C_NONE, S_TSGN2,         16'h7FFF, 16'h0000, 2'd3, 2'b11, 2'b11);
        add("gojam",       C_GJ,   S_ST1,           16'hFFFF, 16'h0000, 2'd0, 2'b11, 2'b00);
        add("xfer_postgj", C_XF,   S_NONE,          16'hFFFF, 16'h0000, 2'd0, 2'b11, 2'b00);
        add("tov_zero",    C_NONE, S_TOV,           16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("st2_mid",     C_NONE, S_ST2,           16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("t12_only",    C_T12,  S_NONE,          16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("xfer_st2",    C_XF,   S_NONE,          16'hFFFF, 16'h0000, 2'd2, 2'b00, 2'b00);
        add("xfer_none",   C_XF,   S_NONE,          16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("xfer_strb",   C_XF,   S_ST1 | S_ST2,   16'hFFFF, 16'h0000, 2'd3, 2'b00, 2'b00);
        add("st1_req",     C_NONE, S_ST1,           16'hFFFF, 16'h0000, 2'd3, 2'b00, 2'b00);
        add("rststg",      C_NONE, S_RSTSTG,        16'hFFFF, 16'h0000, 2'd3, 2'b00, 2'b00);
        add("xfer_clr",    C_XF,   S_NONE,          16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("st1_rst_same",C_NONE, S_ST1 | S_RSTSTG,16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("xfer_st1",    C_XF,   S_NONE,          16'hFFFF, 16'h0000, 2'd1, 2'b00, 2'b00);
        add("trsm",        C_NONE, S_TRSM,          16'hFFFF, 16'h0000, 2'd1, 2'b00, 2'b00);
        add("xfer_trsm",   C_XF,   S_NONE,          16'hFFFF, 16'h0000, 2'd2, 2'b00, 2'b00);
        add("st1_again",   C_NONE, S_ST1,           16'hFFFF, 16'h0000, 2'd2, 2'b00, 2'b00);
        add("xfer_rststg", C_XF,   S_RSTSTG,        16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("tsgn_neg",    C_NONE, S_TSGN,          16'h7FFF, 16'h0000, 2'd0, 2'b01, 2'b01);
        add("tov_4000",    C_NONE, S_TOV,           16'hBFFF, 16'h0000, 2'd0, 2'b10, 2'b10);
        add("tov_8000",    C_NONE, S_TOV,           16'h7FFF, 16'h0000, 2'd0, 2'b11, 2'b11);
        add("tl15_zero",   C_NONE, S_TL15,          16'hFFFF, 16'h0000, 2'd0, 2'b10, 2'b10);
        add("tmz_fffe",    C_NONE, S_TMZ,           16'h0001, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("tmz_ffff",    C_NONE, S_TMZ,           16'h0000, 16'h0000, 2'd0, 2'b10, 2'b10);
        add("tpzg_0001",   C_NONE, S_TPZG,          16'hFFFF, 16'hFFFE, 2'd0, 2'b00, 2'b00);
        add("tpzg_0000",   C_NONE, S_TPZG,          16'hFFFF, 16'hFFFF, 2'd0, 2'b10, 2'b10);
        add("tsgn2_pos",   C_NONE, S_TSGN2,         16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("tov_over_tmz",C_NONE, S_TOV | S_TMZ,   16'h0000, 16'h0000, 2'd0, 2'b01, 2'b01);
        add("tsgn_over_tl15",C_NONE,S_TSGN | S_TL15,16'hBFFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("tpzg_over_tsgn2",C_NONE,S_TPZG|S_TSGN2,16'hFFFF, 16'hFFFF, 2'd0, 2'b10, 2'b10);
        add("br_on_xfer",  C_XF,   S_TSGN,          16'h7FFF, 16'h0000, 2'd0, 2'b11, 2'b11);
        add("br_on_gojam", C_GJ,   S_TSGN,          16'hFFFF, 16'h0000, 2'd0, 2'b10, 2'b00);
        add("rst_override",C_RST | C_GJ | C_XF, S_ST1 | S_ST2 | S_TSGN, 16'h7FFF, 16'h0000, 2'd0, 2'b00, 2'b00);
        add("xfer_postrst",C_XF,   S_NONE,          16'hFFFF, 16'h0000, 2'd0, 2'b00, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, vecs[i].ctrl, vecs[i].strb, vecs[i].wl_n, vecs[i].g_n,
                 vecs[i].exp_cs, vecs[i].exp_br0, vecs[i].exp_br1);
        end

        // Randomized branch tests; both instances track the same model here.
        m1 = 1'b0;
        m2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rs = 10'($urandom_range(0, 63));
            case ($urandom_range(0, 4))
                0:       rwl_n = 16'h0000;
                1:       rwl_n = 16'hFFFF;
                2:       rwl_n = 16'h7FFF;
                3:       rwl_n = 16'hBFFF;
                default: rwl_n = 16'($urandom);
            endcase
            if ($urandom_range(0, 1) == 0) rg_n = 16'hFFFF;
            else                           rg_n = 16'($urandom);
            wl = ~rwl_n;
            g  = ~rg_n;
            if (rs[2])      m1 = wl[15];
            else if (rs[5]) m1 = wl[15];
            else if (rs[3]) m1 = wl[14];
            if (rs[2])      m2 = wl[15] ^ wl[14];
            else if (rs[1]) m2 = (wl == 16'hFFFF);
            else if (rs[0]) m2 = (g == 16'h0000);
            else if (rs[4]) m2 = wl[15];
            step("rand_branch", C_NONE, rs, rwl_n, rg_n, 2'd0, {m2, m1}, {m2, m1});
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
